hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
//  Parametrised hazard controller for the 5-stage pipeline. It combines per-operand EX-stage
//  forwarding selection with load-use stall sequencing, memory-wait freezing and taken-branch
//  flushing. It sits beside the pipeline latches and drives PC/latch enables, flushes and the
//  ALU operand muxes.
// PARAMETERS
//  REG_AW   5   register-index width
//  NSRC     2   source operands per instruction (rs, rt, ...); operand i uses bits [i*REG_AW +: REG_AW]
//  LOAD_LAT 1   stall cycles a load in EX imposes on a dependent ID instruction (1..7)
//  CNT_W    16  width of statistics counters
// PORTS
//  CLK           in   1             clock
//  RST           in   1             reset, asynchronous, active-high
//  id_src        in   NSRC*REG_AW   ID-stage source register indices
//  id_src_use    in   NSRC          1 = ID instruction actually reads operand i
//  ex_src        in   NSRC*REG_AW   EX-stage source register indices
//  ex_memread    in   1             EX instruction is a load
//  ex_wen/ex_wsel  in 1/REG_AW      EX writeback enable / destination
//  m_wen/m_wsel    in 1/REG_AW      MEM writeback enable / destination
//  w_wen/w_wsel    in 1/REG_AW      WB writeback enable / destination
//  branch_taken  in   1             branch/jump resolved taken in EX
//  dmem_wait     in   1             data memory not ready; pipeline must freeze
//  pc_en         out  1             PC load enable
//  ifid_en       out  1             IF/ID latch enable
//  ifid_flush    out  1             IF/ID latch clears to NOP
//  idex_nop      out  1             ID/EX latch loads a bubble
//  pipe_en       out  1             EX/MEM and MEM/WB latch enable
//  fwd_sel       out  2*NSRC        per-operand mux: 00 regfile, 01 MEM, 10 WB
//  stall_cycles  out  CNT_W         statistics (see CONFIGURATION)
//  flush_count   out  CNT_W         statistics
// BEHAVIOUR
//  - Forwarding, combinational, per operand i: MEM match (m_wen, m_wsel!=0, m_wsel==ex_src[i]) -> 01;
//    else WB match -> 10; else 00. MEM has priority because it is the newer result.
//  - lu_hit = ex_memread & ex_wen & ex_wsel!=0 & OR_i(id_src_use[i] & id_src[i]==ex_wsel).
//  - FSM states: RUN and LU_STALL, with counter lu_cnt[2:0]. Outputs are combinational from the state and inputs.
//  - RUN: lu_hit -> stall cycle (pc_en=0, ifid_en=0, idex_nop=1). If LOAD_LAT>1: go to LU_STALL
//    with lu_cnt=LOAD_LAT-1; otherwise stay in RUN.
//  - LU_STALL: same stall outputs. lu_cnt decrements each non-frozen cycle; on lu_cnt==1 -> RUN.
//  - Default (RUN, no event): pc_en=ifid_en=pipe_en=1, flushes=0, idex_nop=0.
//  - dmem_wait=1 overrides everything. pc_en=ifid_en=pipe_en=0, idex_nop=0, flushes=0.
//    The state and lu_cnt hold, and branch_taken is ignored until dmem_wait drops.
//  - branch_taken (no dmem_wait) beats a load-use stall. pc_en=1, ifid_flush=1, idex_nop=1.
//    The FSM forces RUN with lu_cnt=0, because the dependent instruction is wrong-path.
//  - Reset: state=RUN, lu_cnt=0, stats=0. Outputs take their RUN-decode values.
//    Asserting RST mid-stall abandons the stall immediately.
//  - Zero register: index 0 never forwards and never causes a stall.
// CONFIGURATION
//  HAZARD_STATS_EN defined:
//  - stall_cycles increments each cycle with lu_hit or state==LU_STALL (dmem_wait=0).
//  - flush_count increments each cycle with a taken-branch flush.
//  - Both saturate at 2**CNT_W-1 and clear on RST.
//  HAZARD_STATS_EN undefined: no counter flops; stall_cycles and flush_count are tied to 0.
// TESTING
//  1. m: wsel=3, wen=1; w: wsel=3, wen=1; ex_src[0]=3 -> fwd_sel[1:0]=01 (MEM wins); m_wen=0 -> 10.
//  2. lw $5 in EX, id_src[1]=5, use=1, LOAD_LAT=1 -> one cycle pc_en=0, idex_nop=1, then RUN.
//     With use=0 -> no stall.
//  3. LOAD_LAT=3, load-use hit -> exactly 3 stall cycles. dmem_wait=1 for 2 cycles mid-stall
//     -> 5 cycles total, with pipe_en=0 during the wait.
//  4. lu_hit and branch_taken in the same cycle -> ifid_flush=1, idex_nop=1, pc_en=1, and no stall next cycle.
//  5. RST pulse during LU_STALL (LOAD_LAT=3, lu_cnt=2) -> next cycle pc_en=1 and state RUN.
//     ex_wsel=0 load with id_src=0 -> no stall.
//  6. With HAZARD_STATS_EN, CNT_W=4, 20 stall cycles -> stall_cycles=15 (saturated); RST -> 0.

Source files
------------

// File: rtl/hazard_ctrl_unit_if.sv
// Hazard controller bundle: pipeline hazard inputs and control outputs.
// master drives hazard inputs; slave (the controller) drives control outputs.
interface hazard_ctrl_unit_if #(
  parameter int REG_AW = 5,
  parameter int NSRC   = 2,
  parameter int CNT_W  = 16
);
  logic [NSRC*REG_AW-1:0] id_src;
  logic [NSRC-1:0]        id_src_use;
  logic [NSRC*REG_AW-1:0] ex_src;
  logic                   ex_memread;
  logic                   ex_wen;
  logic [REG_AW-1:0]      ex_wsel;
  logic                   m_wen;
  logic [REG_AW-1:0]      m_wsel;
  logic                   w_wen;
  logic [REG_AW-1:0]      w_wsel;
  logic                   branch_taken;
  logic                   dmem_wait;
  logic                   pc_en;
  logic                   ifid_en;
  logic                   ifid_flush;
  logic                   idex_nop;
  logic                   pipe_en;
  logic [2*NSRC-1:0]      fwd_sel;
  logic [CNT_W-1:0]       stall_cycles;
  logic [CNT_W-1:0]       flush_count;

  modport master (
    output id_src, id_src_use, ex_src, ex_memread,
    output ex_wen, ex_wsel, m_wen, m_wsel,
    output w_wen, w_wsel, branch_taken, dmem_wait,
    input  pc_en, ifid_en, ifid_flush, idex_nop,
    input  pipe_en, fwd_sel, stall_cycles, flush_count
  );

  modport slave (
    input  id_src, id_src_use, ex_src, ex_memread,
    input  ex_wen, ex_wsel, m_wen, m_wsel,
    input  w_wen, w_wsel, branch_taken, dmem_wait,
    output pc_en, ifid_en, ifid_flush, idex_nop,
    output pipe_en, fwd_sel, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller: EX forwarding, load-use stalls, memory freeze, branch flush.
// Optional statistics counters enabled by defining HAZARD_STATS_EN.
module hazard_ctrl_unit #(
  parameter int REG_AW   = 5,
  parameter int NSRC     = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input logic              clk,
  input logic              rst,
  hazard_ctrl_unit_if.slave bus
);

  typedef enum logic {
    RUN,
    LU_STALL
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

  state_t            state_q;
  state_t            state_d;
  logic [2:0]        cnt_q;
  logic [2:0]        cnt_d;
  logic [NSRC-1:0]   m_match;
  logic [NSRC-1:0]   w_match;
  logic [NSRC-1:0]   use_match;
  logic [2*NSRC-1:0] fwd;
  logic              lu_hit;
  logic              pc_en;
  logic              ifid_en;
  logic              ifid_flush;
  logic              idex_nop;
  logic              pipe_en;

  // Per-operand register index comparisons against EX, MEM and WB
  always_comb begin
    m_match   = '0;
    w_match   = '0;
    use_match = '0;
    for (int i = 0; i < NSRC; i++) begin
      m_match[i] = bus.m_wen
                && (bus.m_wsel != '0)
                && (bus.m_wsel == bus.ex_src[i*REG_AW +: REG_AW]);
      w_match[i] = bus.w_wen
                && (bus.w_wsel != '0)
                && (bus.w_wsel == bus.ex_src[i*REG_AW +: REG_AW]);
      use_match[i] = bus.id_src_use[i]
                  && (bus.id_src[i*REG_AW +: REG_AW] == bus.ex_wsel);
    end
  end

  // Forward mux select; MEM holds the newer result so it wins over WB
  always_comb begin
    fwd = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (m_match[i]) begin
        fwd[2*i +: 2] = 2'b01;
      end else if (w_match[i]) begin
        fwd[2*i +: 2] = 2'b10;
      end
    end
  end

  assign lu_hit = bus.ex_memread
               && bus.ex_wen
               && (bus.ex_wsel != '0)
               && (|use_match);

  // Stall state register; reset abandons any stall in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and pipeline enables; memory wait freezes, then branch, then stall
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_nop   = 1'b0;
    pipe_en    = 1'b1;
    if (bus.dmem_wait) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      pipe_en = 1'b0;
    end else if (bus.branch_taken) begin
      ifid_flush = 1'b1;
      idex_nop   = 1'b1;
      state_d    = RUN;
      cnt_d      = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (lu_hit) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_nop = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = LU_STALL;
              cnt_d   = LAT_M1;
            end
          end
        end
        LU_STALL: begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_nop = 1'b1;
          cnt_d    = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign bus.pc_en      = pc_en;
  assign bus.ifid_en    = ifid_en;
  assign bus.ifid_flush = ifid_flush;
  assign bus.idex_nop   = idex_nop;
  assign bus.pipe_en    = pipe_en;
  assign bus.fwd_sel    = fwd;

`ifdef HAZARD_STATS_EN
  logic             stall_ev;
  logic             flush_ev;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  assign stall_ev = !bus.dmem_wait
                 && (lu_hit || (state_q == LU_STALL));
  assign flush_ev = !bus.dmem_wait && bus.branch_taken;

  // Saturating count of load-use stall cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (stall_ev && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  // Saturating count of taken-branch flush cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q <= '0;
    end else if (flush_ev && (flush_q != '1)) begin
      flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: LOAD_LAT=1 and LOAD_LAT=3 instances side by side.
// Forward table, directed stall/flush/reset sequences, random vs reference model.
module tb_hazard_ctrl_unit;
  localparam int AW   = 5;
  localparam int NS   = 2;
  localparam int CW_A = 16;
  localparam int CW_B = 4;
  localparam int LL_A = 1;
  localparam int LL_B = 3;

  localparam logic [4:0] C_RUN   = 5'b11001;
  localparam logic [4:0] C_STALL = 5'b00011;
  localparam logic [4:0] C_FLUSH = 5'b11111;
  localparam logic [4:0] C_FRZ   = 5'b00000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NS*AW-1:0] id_src;
  logic [NS*AW-1:0] ex_src;
  logic [NS-1:0]    id_src_use;
  logic             ex_memread;
  logic             ex_wen;
  logic             m_wen;
  logic             w_wen;
  logic             branch_taken;
  logic             dmem_wait;
  logic [AW-1:0]    ex_wsel;
  logic [AW-1:0]    m_wsel;
  logic [AW-1:0]    w_wsel;

  hazard_ctrl_unit_if #(.REG_AW(AW), .NSRC(NS), .CNT_W(CW_A)) ifa ();
  hazard_ctrl_unit_if #(.REG_AW(AW), .NSRC(NS), .CNT_W(CW_B)) ifb ();

  assign ifa.id_src       = id_src;
  assign ifa.id_src_use   = id_src_use;
  assign ifa.ex_src       = ex_src;
  assign ifa.ex_memread   = ex_memread;
  assign ifa.ex_wen       = ex_wen;
  assign ifa.ex_wsel      = ex_wsel;
  assign ifa.m_wen        = m_wen;
  assign ifa.m_wsel       = m_wsel;
  assign ifa.w_wen        = w_wen;
  assign ifa.w_wsel       = w_wsel;
  assign ifa.branch_taken = branch_taken;
  assign ifa.dmem_wait    = dmem_wait;
  assign ifb.id_src       = id_src;
  assign ifb.id_src_use   = id_src_use;
  assign ifb.ex_src       = ex_src;
  assign ifb.ex_memread   = ex_memread;
  assign ifb.ex_wen       = ex_wen;
  assign ifb.ex_wsel      = ex_wsel;
  assign ifb.m_wen        = m_wen;
  assign ifb.m_wsel       = m_wsel;
  assign ifb.w_wen        = w_wen;
  assign ifb.w_wsel       = w_wsel;
  assign ifb.branch_taken = branch_taken;
  assign ifb.dmem_wait    = dmem_wait;

  hazard_ctrl_unit #(
    .REG_AW(AW), .NSRC(NS), .LOAD_LAT(LL_A), .CNT_W(CW_A)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );

  hazard_ctrl_unit #(
    .REG_AW(AW), .NSRC(NS), .LOAD_LAT(LL_B), .CNT_W(CW_B)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---- reference model: remaining stall cycles and saturating stats ----
  int rem_a = 0, rem_b = 0;
  int sc_a = 0, fc_a = 0, sc_b = 0, fc_b = 0;

  function automatic bit hit_f();
    if (!(ex_memread && ex_wen && ex_wsel != 0)) return 1'b0;
    for (int i = 0; i < NS; i++)
      if (id_src_use[i] && id_src[i*AW +: AW] == ex_wsel) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [4:0] ctl_f(int rem);
    if (dmem_wait) return C_FRZ;
    if (branch_taken) return C_FLUSH;
    if (rem > 0 || hit_f()) return C_STALL;
    return C_RUN;
  endfunction

  function automatic logic [3:0] fwd_f();
    logic [3:0] r;
    logic [AW-1:0] s;
    r = '0;
    for (int i = 0; i < NS; i++) begin
      s = ex_src[i*AW +: AW];
      if (m_wen && m_wsel != 0 && m_wsel == s) r[2*i +: 2] = 2'b01;
      else if (w_wen && w_wsel != 0 && w_wsel == s) r[2*i +: 2] = 2'b10;
    end
    return r;
  endfunction

  function automatic int nrem(int rem, int ll);
    if (dmem_wait) return rem;
    if (branch_taken) return 0;
    if (rem > 0) return rem - 1;
    if (hit_f()) return ll - 1;
    return rem;
  endfunction

  function automatic int sat(int v, int cw);
    int mx;
    mx = (1 << cw) - 1;
    return (v + 1 > mx) ? mx : v + 1;
  endfunction

  function automatic int nsc(int sc, int rem, int cw);
    if (dmem_wait) return sc;
    if (hit_f() || rem > 0) return sat(sc, cw);
    return sc;
  endfunction

  function automatic int nfc(int fc, int cw);
    if (!dmem_wait && branch_taken) return sat(fc, cw);
    return fc;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_a <= 0; rem_b <= 0;
      sc_a <= 0; fc_a <= 0; sc_b <= 0; fc_b <= 0;
    end else begin
      rem_a <= nrem(rem_a, LL_A);
      rem_b <= nrem(rem_b, LL_B);
      sc_a  <= nsc(sc_a, rem_a, CW_A);
      sc_b  <= nsc(sc_b, rem_b, CW_B);
      fc_a  <= nfc(fc_a, CW_A);
      fc_b  <= nfc(fc_b, CW_B);
    end
  end

  function automatic int st_exp(int v);
`ifdef HAZARD_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  function automatic logic [4:0] ctl_a();
    return {ifa.pc_en, ifa.ifid_en, ifa.ifid_flush, ifa.idex_nop, ifa.pipe_en};
  endfunction

  function automatic logic [4:0] ctl_b();
    return {ifb.pc_en, ifb.ifid_en, ifb.ifid_flush, ifb.idex_nop, ifb.pipe_en};
  endfunction

  task automatic clear_in();
    id_src = '0; ex_src = '0; id_src_use = '0;
    ex_memread = 0; ex_wen = 0; ex_wsel = '0;
    m_wen = 0; m_wsel = '0; w_wen = 0; w_wsel = '0;
    branch_taken = 0; dmem_wait = 0;
  endtask

  task automatic set_load(logic [AW-1:0] rd, logic [NS*AW-1:0] srcs,
                          logic [NS-1:0] use_v);
    ex_memread = 1; ex_wen = 1; ex_wsel = rd;
    id_src = srcs; id_src_use = use_v;
  endtask

  task automatic chk_model(string tag);
    check({tag, "_ctl_a"}, 32'(ctl_a()), 32'(ctl_f(rem_a)));
    check({tag, "_ctl_b"}, 32'(ctl_b()), 32'(ctl_f(rem_b)));
    check({tag, "_fwd"}, 32'(ifa.fwd_sel), 32'(fwd_f()));
    check({tag, "_sc_b"}, 32'(ifb.stall_cycles), 32'(st_exp(sc_b)));
    check({tag, "_fc_b"}, 32'(ifb.flush_count), 32'(st_exp(fc_b)));
    check({tag, "_sc_a"}, 32'(ifa.stall_cycles), 32'(st_exp(sc_a)));
  endtask

  typedef struct {
    logic [NS*AW-1:0] ex_src;
    logic             m_wen;
    logic [AW-1:0]    m_wsel;
    logic             w_wen;
    logic [AW-1:0]    w_wsel;
    logic [3:0]       exp_fwd;
  } fvec_t;

  fvec_t tbl[8];

  initial begin
    logic [4:0] exp3[6];
    int frozen;

    tbl[0] = '{{5'd0, 5'd3}, 1'b1, 5'd3, 1'b1, 5'd3, 4'b0001};
    tbl[1] = '{{5'd0, 5'd3}, 1'b0, 5'd3, 1'b1, 5'd3, 4'b0010};
    tbl[2] = '{{5'd0, 5'd0}, 1'b1, 5'd0, 1'b1, 5'd0, 4'b0000};
    tbl[3] = '{{5'd7, 5'd4}, 1'b1, 5'd7, 1'b1, 5'd4, 4'b0110};
    tbl[4] = '{{5'd5, 5'd5}, 1'b0, 5'd5, 1'b1, 5'd5, 4'b1010};
    tbl[5] = '{{5'd5, 5'd5}, 1'b1, 5'd5, 1'b0, 5'd5, 4'b0101};
    tbl[6] = '{{5'd6, 5'd2}, 1'b1, 5'd9, 1'b1, 5'd1, 4'b0000};
    tbl[7] = '{{5'd31, 5'd31}, 1'b1, 5'd31, 1'b1, 5'd31, 4'b0101};

    clear_in();
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_ctl_a", 32'(ctl_a()), 32'(C_RUN));
    check("reset_ctl_b", 32'(ctl_b()), 32'(C_RUN));
    check("reset_sc_b", 32'(ifb.stall_cycles), 32'd0);
    check("reset_fc_b", 32'(ifb.flush_count), 32'd0);
    rst = 0;
    @(negedge clk);

    // forwarding table
    for (int i = 0; i < 8; i++) begin
      ex_src = tbl[i].ex_src;
      m_wen = tbl[i].m_wen; m_wsel = tbl[i].m_wsel;
      w_wen = tbl[i].w_wen; w_wsel = tbl[i].w_wsel;
      #1;
      check($sformatf("fwd_a_%0d", i), 32'(ifa.fwd_sel), 32'(tbl[i].exp_fwd));
      check($sformatf("fwd_b_%0d", i), 32'(ifb.fwd_sel), 32'(tbl[i].exp_fwd));
      @(negedge clk);
    end
    clear_in();
    @(negedge clk);

    // single load-use stall (A), three-cycle stall (B)
    set_load(5'd5, {5'd5, 5'd0}, 2'b10);
    #1;
    check("lu1_a_stall", 32'(ctl_a()), 32'(C_STALL));
    check("lu1_b_stall", 32'(ctl_b()), 32'(C_STALL));
    @(negedge clk);
    clear_in();
    #1;
    check("lu1_a_done", 32'(ctl_a()), 32'(C_RUN));
    check("lu3_b_c1", 32'(ctl_b()), 32'(C_STALL));
    @(negedge clk);
    #1;
    check("lu3_b_c2", 32'(ctl_b()), 32'(C_STALL));
    @(negedge clk);
    #1;
    check("lu3_b_done", 32'(ctl_b()), 32'(C_RUN));
    @(negedge clk);

    // operand not used: no stall
    set_load(5'd5, {5'd5, 5'd0}, 2'b01);
    #1;
    check("nouse_a", 32'(ctl_a()), 32'(C_RUN));
    check("nouse_b", 32'(ctl_b()), 32'(C_RUN));
    @(negedge clk);
    clear_in();
    @(negedge clk);

    // memory wait mid-stall, with a taken branch that must be ignored
    exp3 = '{C_STALL, C_STALL, C_FRZ, C_FRZ, C_STALL, C_RUN};
    frozen = 0;
    for (int c = 0; c < 6; c++) begin
      clear_in();
      if (c == 0) set_load(5'd9, {5'd0, 5'd9}, 2'b01);
      if (c == 2 || c == 3) begin
        dmem_wait = 1;
        branch_taken = 1;
      end
      #1;
      check($sformatf("wait_b_c%0d", c), 32'(ctl_b()), 32'(exp3[c]));
      if (!ifb.pc_en) frozen++;
      @(negedge clk);
    end
    check("wait_b_total", 32'(frozen), 32'd5);
    clear_in();

    // load-use and branch together: branch wins, no stall afterwards
    set_load(5'd4, {5'd4, 5'd4}, 2'b11);
    branch_taken = 1;
    #1;
    check("br_lu_a", 32'(ctl_a()), 32'(C_FLUSH));
    check("br_lu_b", 32'(ctl_b()), 32'(C_FLUSH));
    @(negedge clk);
    clear_in();
    #1;
    check("br_after_a", 32'(ctl_a()), 32'(C_RUN));
    check("br_after_b", 32'(ctl_b()), 32'(C_RUN));
    @(negedge clk);

    // reset pulse during a stall abandons it
    set_load(5'd8, {5'd8, 5'd0}, 2'b10);
    #1;
    check("rst_pre_b", 32'(ctl_b()), 32'(C_STALL));
    @(negedge clk);
    clear_in();
    rst = 1;
    #1;
    check("rst_mid_b", 32'(ctl_b()), 32'(C_RUN));
    #1;
    rst = 0;
    @(negedge clk);
    #1;
    check("rst_after_b", 32'(ctl_b()), 32'(C_RUN));
    @(negedge clk);

    // zero register load never stalls
    set_load(5'd0, {5'd0, 5'd0}, 2'b11);
    #1;
    check("zero_a", 32'(ctl_a()), 32'(C_RUN));
    check("zero_b", 32'(ctl_b()), 32'(C_RUN));
    @(negedge clk);
    clear_in();

    // 20 stall cycles: 4-bit counter saturates at 15
    rst = 1;
    #1;
    rst = 0;
    set_load(5'd6, {5'd6, 5'd6}, 2'b11);
    repeat (20) @(negedge clk);
    #1;
    check("sat_sc_b", 32'(ifb.stall_cycles), 32'(st_exp(15)));
    check("sat_sc_a", 32'(ifa.stall_cycles), 32'(st_exp(20)));
    rst = 1;
    #1;
    check("sat_rst_b", 32'(ifb.stall_cycles), 32'd0);
    #1;
    rst = 0;
    clear_in();
    @(negedge clk);

    // random stimulus against the reference model
    for (int n = 0; n < 500; n++) begin
      id_src       = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      ex_src       = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      id_src_use   = 2'($urandom_range(0, 3));
      ex_memread   = ($urandom_range(0, 2) != 0);
      ex_wen       = ($urandom_range(0, 3) != 0);
      ex_wsel      = 5'($urandom_range(0, 3));
      m_wen        = 1'($urandom);
      m_wsel       = 5'($urandom_range(0, 3));
      w_wen        = 1'($urandom);
      w_wsel       = 5'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 7) == 0);
      dmem_wait    = ($urandom_range(0, 4) == 0);
      rst          = ($urandom_range(0, 59) == 0);
      #1;
      chk_model($sformatf("rnd%0d", n));
      @(negedge clk);
      rst = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
